// File: rtl/project_switch_sequencer_if.sv
// rtl/project_switch_sequencer_if.sv - request/pad-control bundle between register decode and the switch sequencer
//
// Purpose: groups the switch request handshake together with the IO-mux and reset
// controls that the sequencer produces.
// Ports (signals):
//   req_valid / req_ready      request handshake (master -> sequencer / sequencer -> master)
//   req_project [7:0]          requested project id
//   req_oeb [IO_PADS-1:0]      oeb map applied when the switch completes
//   active_project [7:0]       io mux select
//   io_oeb [IO_PADS-1:0]       pad output enables, active low
//   project_rst [NUM_PROJECTS] per-project reset, active high
//   busy / done / err          status
interface project_switch_sequencer_if #(
  parameter int NUM_PROJECTS = 8,
  parameter int IO_PADS      = 38
);
  logic                    req_valid;
  logic                    req_ready;
  logic [7:0]              req_project;
  logic [IO_PADS-1:0]      req_oeb;
  logic [7:0]              active_project;
  logic [IO_PADS-1:0]      io_oeb;
  logic [NUM_PROJECTS-1:0] project_rst;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output req_valid, req_project, req_oeb,
    input  req_ready, active_project, io_oeb, project_rst, busy, done, err
  );

  modport slave (
    input  req_valid, req_project, req_oeb,
    output req_ready, active_project, io_oeb, project_rst, busy, done, err
  );
endinterface

// File: rtl/project_switch_sequencer.sv
// rtl/project_switch_sequencer.sv - safe hand-over of the shared user IO pads between projects
//
// Purpose: on an accepted request, tristates all pads, holds every project in reset,
// changes the mux select, holds the new project in reset for a settle period, then
// releases it and applies the requested oeb map.
// Ports:
//   clk      system (wishbone) clock
//   reset_n  asynchronous active-low reset
//   bus      project_switch_sequencer_if.slave (request handshake, mux select,
//            io_oeb, project_rst, busy/done/err)
module project_switch_sequencer #(
  parameter int NUM_PROJECTS = 8,
  parameter int IO_PADS      = 38,
  parameter int DRAIN_CYCLES = 4,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  project_switch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRISTATE = 2'd1,
    S_SWAP     = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  localparam int MAX_CYCLES = (DRAIN_CYCLES > HOLD_CYCLES) ? DRAIN_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Counters load "cycles - 1" and the state exits on the cycle the count reads zero,
  // so a phase of N cycles spends exactly N cycles in its state.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [8:0]       ID_LIMIT   = 9'(NUM_PROJECTS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [7:0]           r_target_project;
  logic [7:0]           w_target_project_nxt;
  logic [IO_PADS-1:0]   r_target_oeb;
  logic [IO_PADS-1:0]   w_target_oeb_nxt;
  logic [7:0]           r_active_project;
  logic [7:0]           w_active_project_nxt;
  logic [IO_PADS-1:0]   r_io_oeb;
  logic [IO_PADS-1:0]   w_io_oeb_nxt;
  logic                 r_live;
  logic                 w_live_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_err;
  logic                 w_err_nxt;

  logic                 w_accept;
  logic                 w_req_invalid;
  logic [NUM_PROJECTS-1:0] w_project_rst;

  assign w_accept      = bus.req_valid && (r_state == S_IDLE);
  assign w_req_invalid = ({1'b0, bus.req_project} >= ID_LIMIT);

  // State register, together with the datapath registers it sequences.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_target_project <= '0;
      r_target_oeb     <= '0;
      r_active_project <= '0;
      r_io_oeb         <= '1;
      r_live           <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_target_project <= w_target_project_nxt;
      r_target_oeb     <= w_target_oeb_nxt;
      r_active_project <= w_active_project_nxt;
      r_io_oeb         <= w_io_oeb_nxt;
      r_live           <= w_live_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
      r_err            <= w_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && !w_req_invalid) w_state_nxt = S_TRISTATE;
      S_TRISTATE: if (r_cnt == '0) w_state_nxt = S_SWAP;
      S_SWAP:     w_state_nxt = S_HOLD;
      S_HOLD:     if (r_cnt == '0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath logic. Pads go all-ones on the accept edge and stay there until
  // the HOLD exit edge, so the select change in SWAP always happens with pads tristated.
  always_comb begin
    w_cnt_nxt            = r_cnt;
    w_target_project_nxt = r_target_project;
    w_target_oeb_nxt     = r_target_oeb;
    w_active_project_nxt = r_active_project;
    w_io_oeb_nxt         = r_io_oeb;
    w_live_nxt           = r_live;
    w_busy_nxt           = r_busy;
    w_done_nxt           = 1'b0;
    w_err_nxt            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_invalid) begin
            w_err_nxt = 1'b1;
          end else begin
            w_target_project_nxt = bus.req_project;
            w_target_oeb_nxt     = bus.req_oeb;
            w_io_oeb_nxt         = '1;
            w_live_nxt           = 1'b0;
            w_busy_nxt           = 1'b1;
            w_cnt_nxt            = DRAIN_LOAD;
          end
        end
      end
      S_TRISTATE: begin
        w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
      end
      S_SWAP: begin
        w_active_project_nxt = r_target_project;
        w_cnt_nxt            = HOLD_LOAD;
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_io_oeb_nxt = r_target_oeb;
          w_live_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Only the live, selected project is out of reset; derived purely from registers.
  always_comb begin
    w_project_rst = '1;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      if (r_live && (r_active_project == 8'(i))) w_project_rst[i] = 1'b0;
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.active_project = r_active_project;
  assign bus.io_oeb         = r_io_oeb;
  assign bus.project_rst    = w_project_rst;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err            = r_err;

endmodule

// File: tb/tb_project_switch_sequencer.sv
// tb/tb_project_switch_sequencer.sv - self-checking bench for project_switch_sequencer
module tb_project_switch_sequencer;
  localparam int NP = 8;
  localparam int IO = 38;
  localparam int D  = 4;
  localparam int H  = 8;
  localparam logic [IO-1:0] ONES = '1;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  logic [7:0]    m_active;
  logic [IO-1:0] m_oeb;
  logic          m_live;

  project_switch_sequencer_if #(.NUM_PROJECTS(NP), .IO_PADS(IO)) bus ();

  project_switch_sequencer #(
    .NUM_PROJECTS(NP), .IO_PADS(IO), .DRAIN_CYCLES(D), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] exp_rst(input logic live, input logic [7:0] act);
    logic [NP-1:0] r;
    r = '1;
    if (live && act < NP) r[act[2:0]] = 1'b0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] e_act, input logic [IO-1:0] e_oeb,
                               input logic e_live, input logic e_busy, input logic e_done,
                               input logic e_err, input logic e_ready);
    check({tag, ".active"}, 64'(bus.active_project), 64'(e_act));
    check({tag, ".oeb"},    64'(bus.io_oeb),         64'(e_oeb));
    check({tag, ".rst"},    64'(bus.project_rst),    64'(exp_rst(e_live, e_act)));
    check({tag, ".busy"},   64'(bus.busy),           64'(e_busy));
    check({tag, ".done"},   64'(bus.done),           64'(e_done));
    check({tag, ".err"},    64'(bus.err),            64'(e_err));
    check({tag, ".ready"},  64'(bus.req_ready),      64'(e_ready));
  endtask

  // Issues one request at a negedge; then, after each edge E0..Elast, compares the DUT
  // with the timeline the switch rules give. extra_at drives an ignored second request,
  // rst_at pulls reset mid-switch and ends the task.
  task automatic do_request(input string tag, input logic [7:0] p, input logic [IO-1:0] m,
                            input int extra_at, input int rst_at);
    logic          valid;
    int            last;
    logic [7:0]    e_act;
    logic [IO-1:0] e_oeb;
    logic          e_live, e_busy, e_done, e_err, e_ready;
    valid = (p < NP);
    last  = valid ? D + H + 2 : 1;
    bus.req_valid   = 1'b1;
    bus.req_project = p;
    bus.req_oeb     = m;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k <= last; k++) begin
      e_act = m_active; e_oeb = m_oeb; e_live = m_live;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
      if (!valid) begin
        e_err = (k == 0);
      end else if (k <= D + H) begin
        e_oeb = ONES; e_live = 1'b0; e_busy = 1'b1; e_ready = 1'b0;
        if (k >= D + 1) e_act = p;
      end else begin
        e_act = p; e_oeb = m; e_live = 1'b1;
        e_done = (k == D + H + 1);
      end
      check_outputs($sformatf("%s.k%0d", tag, k), e_act, e_oeb, e_live, e_busy, e_done, e_err, e_ready);
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_outputs($sformatf("%s.rst_mid", tag), 8'd0, ONES, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        m_active = 8'd0; m_oeb = ONES; m_live = 1'b0;
        return;
      end
      if (k == extra_at) begin
        bus.req_valid   = 1'b1;
        bus.req_project = 8'd3;
        bus.req_oeb     = ONES;
      end
      if (k == extra_at + 2) bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    if (valid) begin
      m_active = p; m_oeb = m; m_live = 1'b1;
    end
  endtask

  initial begin
    logic [7:0]    rp;
    logic [IO-1:0] rm;
    reset_n         = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_project = 8'd0;
    bus.req_oeb     = '0;
    m_active = 8'd0; m_oeb = ONES; m_live = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs("reset_idle", 8'd0, ONES, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_rst_const", 64'(bus.project_rst), 64'h00FF);

    do_request("p2", 8'd2, '0, -1, -1);
    check("p2_rst_const", 64'(bus.project_rst), 64'h00FB);
    do_request("p9_invalid", 8'd9, ONES, -1, -1);
    do_request("p2_restart", 8'd2, 38'h15_5555_AAAA, -1, -1);
    do_request("p5_extra", 8'd5, 38'h0F_0F0F_0F0F, 2, -1);
    check("p5_final_active", 64'(bus.active_project), 64'd5);

    for (int n = 0; n < 20; n++) begin
      rp = 8'($urandom_range(0, 11));
      rm = 38'({$urandom(), $urandom()});
      do_request($sformatf("rand%0d", n), rp, rm, -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    do_request("p4_reset", 8'd4, 38'h00_0000_FFFF, -1, 6);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_outputs("post_reset", 8'd0, ONES, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_request("p1_after_reset", 8'd1, 38'h3F_0000_0001, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/project_switch_sequencer.md
Name: project_switch_sequencer

Overview:
Sequences a safe hand-over of the shared user IO pads from the active project to a newly requested one. A switch runs in order: tristate all pads, hold every project in reset, change the active-project select, hold the new project in reset for a settle period, then release reset and apply the new output-enable map. It sits between the wishbone register decode and the harness IO mux/oeb drivers, and replaces direct writes to the active-project and oeb registers.

Parameters:
NUM_PROJECTS, 8, number of selectable projects; ids 0..NUM_PROJECTS-1 are valid.
IO_PADS, 38, width of the pad oeb bus.
DRAIN_CYCLES, 4, cycles spent with all pads tristated before the select changes; minimum 1.
HOLD_CYCLES, 8, cycles the new project is held in reset after the select changes; minimum 1.

Ports:
clk  in  1  system clock (wishbone clock).
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  switch request strobe.
req_ready  out  1  high when a request can be accepted.
req_project  in  8  requested project id.
req_oeb  in  IO_PADS  oeb map to apply once the switch completes (1 = input/tristate).
active_project  out  8  mux select for io_in/io_out routing.
io_oeb  out  IO_PADS  pad output-enable bus, active low.
project_rst  out  NUM_PROJECTS  per-project reset, active high.
busy  out  1  high while a switch is in progress.
done  out  1  one-cycle pulse when a switch completes.
err  out  1  one-cycle pulse when a request with an invalid id is accepted.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state = IDLE, active_project = 0, io_oeb = all ones.
  - live = 0, so project_rst = all ones.
  - busy = 0, done = 0, err = 0, counter = 0.
- project_rst[i] = !(live && active_project == i), driven from registers only (no combinational path from req_*).
- req_ready = (state == IDLE). A request is accepted on an edge where req_valid && req_ready.
- Invalid request (req_project >= NUM_PROJECTS):
  - err = 1 for the next cycle.
  - No other state change; active_project, io_oeb and live keep their values.
- Valid request:
  - Latch req_project and req_oeb into target registers.
  - Next state is TRISTATE.
  - A request for the currently active id still runs the full sequence; this is a project restart.
- TRISTATE:
  - On entry: io_oeb = all ones, live = 0, busy = 1.
  - Lasts DRAIN_CYCLES cycles, then moves to SWAP.
- SWAP:
  - Lasts one cycle.
  - active_project <= target id on the exit edge.
  - Next state is HOLD.
- HOLD:
  - Lasts HOLD_CYCLES cycles with live = 0.
  - On the exit edge: state = IDLE, io_oeb = target oeb, live = 1, busy = 0, done = 1.
- done and err clear on the following edge.
- Latency: the accept edge is E0. done, new io_oeb and release of the new project's reset all appear after edge E(DRAIN_CYCLES + HOLD_CYCLES + 1). active_project changes after edge E(DRAIN_CYCLES + 1).
- Ordering invariant: io_oeb never takes a non-all-ones value in the same cycle as a changing active_project. Pads are always tristated across the select change.
- Counter width is $clog2(max(DRAIN_CYCLES, HOLD_CYCLES) + 1). The counter reloads on every state entry and never wraps.
- req_valid while busy is ignored; it is not queued. The requester holds req_valid until req_ready.
- Reset mid-switch: all outputs return asynchronously to their reset values; the target registers are discarded.

Test Plan:
- Release reset, then idle 5 cycles -> active_project = 0, io_oeb = 38'h3F_FFFF_FFFF, project_rst = 8'hFF, req_ready = 1.
- Request project 2 with oeb 38'h0 at E0 (DRAIN = 4, HOLD = 8):
  - io_oeb is all ones from E1 and active_project = 2 after E5.
  - After E13: done pulses once, io_oeb = 0, project_rst = 8'hFB.
- Request project 9 -> err pulses one cycle; active_project, io_oeb and project_rst are unchanged; req_ready stays 1.
- Request project 5, then assert req_valid for project 3 at E2 -> the second request is ignored; the switch ends with active_project = 5.
- With project 2 live, request project 2 -> project_rst[2] goes high from E1 to E13, then releases; done pulses after E13.
- Pull reset_n low at E6 of a switch to project 4 -> immediately active_project = 0, io_oeb = all ones, busy = 0, project_rst = 8'hFF.
